// File: rtl/stream_serializer_if.sv
// Valid/ready stream bundle shared by both sides of stream_serializer.
// The last sideband exists only when STREAM_SERIALIZER_LAST_EN is defined.
interface stream_serializer_if #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
`ifdef STREAM_SERIALIZER_LAST_EN
  logic         last;

  modport master (output data, output valid, output last, input ready);
`else
  modport master (output data, output valid, input ready);
`endif
  // Word-side consumers never look at last, so the slave view omits it.
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_serializer.sv
// Width down-converter: each DIN_WIDTH word leaves as RATIO DOUT_WIDTH slices, LSB first.
// Optional feature macro: STREAM_SERIALIZER_LAST_EN adds the last-slice flag on m_out.
//
// state  | meaning
// S_IDLE | no slice held, din_ready high
// S_BUSY | r_sr[DOUT_WIDTH-1:0] is a valid slice, r_cnt is its index
module stream_serializer #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  stream_serializer_if.slave   s_in,
  stream_serializer_if.master  m_out
);

  localparam int RATIO = DIN_WIDTH / DOUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIN_WIDTH-1:0] r_sr;
  logic [DIN_WIDTH-1:0] w_sr_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  logic w_busy;
  logic w_cnt_last;
  logic w_din_ready;
  logic w_in_xfer;
  logic w_out_xfer;

  assign w_busy     = (r_state == S_BUSY);
  assign w_cnt_last = (r_cnt == LAST_CNT);

  // Ready depends only on own state and downstream ready, never on s_in.valid.
  assign w_din_ready = ~i_rst & (~w_busy | (m_out.ready & w_cnt_last));
  assign w_in_xfer   = s_in.valid & w_din_ready;
  assign w_out_xfer  = w_busy & m_out.ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    if (w_in_xfer) begin
      // Covers the back-to-back case: last slice leaves while the next word loads.
      w_state_nxt = S_BUSY;
      w_sr_nxt    = s_in.data;
      w_cnt_nxt   = '0;
    end else if (w_out_xfer) begin
      if (w_cnt_last) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_sr_nxt  = r_sr >> DOUT_WIDTH;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign s_in.ready  = w_din_ready;
  assign m_out.data  = r_sr[DOUT_WIDTH-1:0];
  assign m_out.valid = w_busy;

`ifdef STREAM_SERIALIZER_LAST_EN
  assign m_out.last  = w_busy & w_cnt_last;
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: directed scenarios plus a random run
// scored against a queue of expected slices built from each accepted word.
module tb_stream_serializer;

  localparam int DW = 32;
  localparam int OW = 8;
  localparam int R  = DW / OW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_serializer_if #(.W(DW)) in_if ();
  stream_serializer_if #(.W(OW)) out_if ();

`ifdef STREAM_SERIALIZER_LAST_EN
  assign in_if.last = 1'b0;
`endif

  stream_serializer #(
    .DIN_WIDTH  (DW),
    .DOUT_WIDTH (OW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_in  (in_if),
    .m_out (out_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } slice_t;

  slice_t q[$];

  logic          p_valid = 1'b0;
  logic          p_ready = 1'b0;
  logic          p_rst   = 1'b1;
  logic [OW-1:0] p_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_last(input string tag, input logic exp);
`ifdef STREAM_SERIALIZER_LAST_EN
    check(tag, {31'b0, out_if.last}, {31'b0, exp});
`endif
  endtask

  // Scoreboard: every cycle, the visible slice must be the oldest unconsumed one.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      check("rst_din_ready", {31'b0, in_if.ready}, 32'd0);
    end else begin
      check("sb_valid", {31'b0, out_if.valid}, {31'b0, (q.size() != 0)});
      if (!p_rst && p_valid && !p_ready) begin
        check("hold_valid", {31'b0, out_if.valid}, 32'd1);
        check("hold_data", {24'b0, out_if.data}, {24'b0, p_data});
      end
      if (out_if.valid && q.size() != 0) begin
        check("sb_data", {24'b0, out_if.data}, {24'b0, q[0].data});
        check_last("sb_last", q[0].last);
        if (out_if.ready) void'(q.pop_front());
      end
      if (in_if.valid && in_if.ready) begin
        for (int k = 0; k < R; k++) begin
          slice_t s;
          s.data = in_if.data[k*OW +: OW];
          s.last = (k == R - 1);
          q.push_back(s);
        end
      end
    end
    p_rst   = rst;
    p_valid = out_if.valid;
    p_ready = out_if.ready;
    p_data  = out_if.data;
  end

  initial begin
    logic [DW-1:0] w;
    logic [DW-1:0] w1;
    int            sent;
    int            cyc;
    logic          hold;
    logic          acc;

    rst          = 1'b1;
    in_if.data   = '0;
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    adv(); adv(); adv();

    // reset state
    settle();
    check("rst_dout_valid", {31'b0, out_if.valid}, 32'd0);
    check("rst_dout", {24'b0, out_if.data}, 32'd0);
    check("rst_ready", {31'b0, in_if.ready}, 32'd0);
    check_last("rst_last", 1'b0);
    rst = 1'b0;
    adv();
    settle();
    check("post_rst_ready", {31'b0, in_if.ready}, 32'd1);

    // single word
    w = 32'hDDCC_BBAA;
    in_if.data   = w;
    in_if.valid  = 1'b1;
    out_if.ready = 1'b1;
    settle();
    check("single_accept_ready", {31'b0, in_if.ready}, 32'd1);
    check("single_pre_valid", {31'b0, out_if.valid}, 32'd0);
    adv();
    in_if.valid = 1'b0;
    for (int k = 0; k < R; k++) begin
      settle();
      check("single_valid", {31'b0, out_if.valid}, 32'd1);
      check("single_data", {24'b0, out_if.data}, {24'b0, w[k*OW +: OW]});
      check_last("single_last", k == R - 1);
      check("single_din_ready", {31'b0, in_if.ready}, {31'b0, (k == R - 1)});
      adv();
    end
    settle();
    check("single_done_valid", {31'b0, out_if.valid}, 32'd0);
    check_last("single_done_last", 1'b0);

    // back-to-back streaming
    w  = 32'h0302_0100;
    w1 = 32'h0706_0504;
    in_if.data  = w;
    in_if.valid = 1'b1;
    settle();
    check("stream_ready0", {31'b0, in_if.ready}, 32'd1);
    adv();
    in_if.data = w1;
    for (int i = 1; i <= 2 * R; i++) begin
      settle();
      check("stream_valid", {31'b0, out_if.valid}, 32'd1);
      check("stream_data", {24'b0, out_if.data}, i - 1);
      check("stream_din_ready", {31'b0, in_if.ready}, {31'b0, ((i - 1) % R == R - 1)});
      adv();
      if (i == R) in_if.valid = 1'b0;
    end
    settle();
    check("stream_done_valid", {31'b0, out_if.valid}, 32'd0);

    // backpressure on the second slice
    w = 32'hDDCC_BBAA;
    in_if.data  = w;
    in_if.valid = 1'b1;
    adv();
    in_if.valid = 1'b0;
    settle();
    check("bp_first", {24'b0, out_if.data}, 32'hAA);
    adv();
    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_hold_data", {24'b0, out_if.data}, 32'hBB);
      check("bp_hold_valid", {31'b0, out_if.valid}, 32'd1);
      check("bp_din_ready", {31'b0, in_if.ready}, 32'd0);
      adv();
    end
    out_if.ready = 1'b1;
    settle();
    check("bp_release", {24'b0, out_if.data}, 32'hBB);
    adv();
    settle();
    check("bp_cc", {24'b0, out_if.data}, 32'hCC);
    adv();
    settle();
    check("bp_dd", {24'b0, out_if.data}, 32'hDD);
    check_last("bp_dd_last", 1'b1);
    adv();
    settle();
    check("bp_done_valid", {31'b0, out_if.valid}, 32'd0);

    // input stall between words
    w = 32'h8877_6655;
    in_if.data  = w;
    in_if.valid = 1'b1;
    adv();
    in_if.valid = 1'b0;
    for (int k = 0; k < R; k++) adv();
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_idle_valid", {31'b0, out_if.valid}, 32'd0);
      adv();
    end
    w = 32'h1234_5678;
    in_if.data  = w;
    in_if.valid = 1'b1;
    settle();
    check("stall_accept_ready", {31'b0, in_if.ready}, 32'd1);
    adv();
    in_if.valid = 1'b0;
    settle();
    check("stall_resume_valid", {31'b0, out_if.valid}, 32'd1);
    check("stall_resume_data", {24'b0, out_if.data}, 32'h78);
    for (int k = 0; k < R; k++) adv();

    // reset in the middle of a word
    w = 32'hDDCC_BBAA;
    in_if.data  = w;
    in_if.valid = 1'b1;
    adv();
    in_if.valid = 1'b0;
    adv();
    adv();
    settle();
    check("midrst_pre", {24'b0, out_if.data}, 32'hCC);
    rst = 1'b1;
    settle();
    check("midrst_ready", {31'b0, in_if.ready}, 32'd0);
    adv();
    rst = 1'b0;
    settle();
    check("midrst_valid", {31'b0, out_if.valid}, 32'd0);
    check("midrst_dout", {24'b0, out_if.data}, 32'd0);
    check_last("midrst_last", 1'b0);
    w = 32'h4433_2211;
    in_if.data  = w;
    in_if.valid = 1'b1;
    adv();
    in_if.valid = 1'b0;
    for (int k = 0; k < R; k++) begin
      settle();
      check("midrst_new_valid", {31'b0, out_if.valid}, 32'd1);
      check("midrst_new_data", {24'b0, out_if.data}, {24'b0, w[k*OW +: OW]});
      adv();
    end

    // random handshakes on both sides
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    while (sent < 1000 && cyc < 40000) begin
      if (!hold) begin
        in_if.valid = 1'($urandom_range(0, 1));
        in_if.data  = DW'($urandom);
      end
      out_if.ready = 1'($urandom_range(0, 1));
      settle();
      acc = in_if.valid & in_if.ready;
      if (acc) sent++;
      hold = in_if.valid & ~acc;
      adv();
      cyc++;
    end
    check("rand_words_sent", sent, 1000);
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    for (int i = 0; i < 4 * R && (q.size() != 0 || out_if.valid); i++) adv();
    settle();
    check("rand_drain_queue", q.size(), 0);
    check("rand_drain_valid", {31'b0, out_if.valid}, 32'd0);

    adv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
# stream_serializer

Width down-converter placed directly downstream of `skid_buffer`. Accepts DIN_WIDTH-bit words over a valid/ready handshake and emits them as RATIO = DIN_WIDTH/DOUT_WIDTH consecutive DOUT_WIDTH-bit slices, LSB slice first, on a second valid/ready handshake. Its `din_ready` drives the skid buffer's `dout_ready`, so it must honour full AXI-stream-style backpressure on both sides without losing or duplicating data.

## Interface
- DIN_WIDTH, 32, input word width; integer multiple of DOUT_WIDTH.
- DOUT_WIDTH, 8, output slice width; RATIO = DIN_WIDTH/DOUT_WIDTH, must be ≥ 2.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DIN_WIDTH  input word.
- din_valid  input  1  input word present.
- din_ready  output  1  block accepts `din` this cycle.
- dout  output  DOUT_WIDTH  current output slice.
- dout_valid  output  1  `dout` holds a valid slice.
- dout_ready  input  1  downstream accepts `dout` this cycle.
- dout_last  output  1  final slice of a word (only with STREAM_SERIALIZER_LAST_EN).

## Operation
- Internal state: DIN_WIDTH shift register `sr`, slice counter `cnt` (width clog2(RATIO)), flag `busy` (= dout_valid).
- Input transfer: `din_valid & din_ready` at a rising edge. Output transfer: `dout_valid & dout_ready`.
- `din_ready = ~rst & (~busy | (dout_ready & cnt == RATIO-1))`: empty, or last slice leaving this cycle. Combinational on `dout_ready`, no combinational path from `din_valid`.
- On input transfer: `sr <= din`, `cnt <= 0`, `busy <= 1`.
- On output transfer without input transfer: if `cnt == RATIO-1` then `busy <= 0`, `cnt <= 0`; else `sr <= sr >> DOUT_WIDTH`, `cnt <= cnt + 1`.
- Input and output transfer in the same cycle (last slice leaving): new word loads; no idle cycle.
- `dout = sr[DOUT_WIDTH-1:0]`; slice k of a word equals `din[k*DOUT_WIDTH +: DOUT_WIDTH]`.
- While `dout_valid & ~dout_ready`: `dout`, `dout_valid`, `cnt` held stable (no change whatsoever).
- `dout_valid` never drops without a completed output transfer of slice RATIO-1.
- When idle, `dout` shows the last shifted value; consumers ignore it (`dout_valid` = 0).
- Counter never exceeds RATIO-1; no wrap beyond it.

## Timing
- Reset (rst high at edge): `dout_valid` 0, `dout` 0, `cnt` 0, `sr` 0, `dout_last` 0. `din_ready` is 0 while rst is high, 1 in the first cycle after.
- Reset mid-word: partial word discarded; no slices of it appear after reset.
- Latency: word accepted at edge N → slice 0 on `dout` with `dout_valid` high in cycle after edge N.
- Throughput: with `din_valid` and `dout_ready` held high, one slice per cycle, one word every RATIO cycles, zero bubbles between words.
- `din_ready` high in exactly one of every RATIO cycles under continuous streaming.

## Configuration
- Macro `STREAM_SERIALIZER_LAST_EN`.
- Defined: port `dout_last` exists; `dout_last = dout_valid & (cnt == RATIO-1)`, stable under backpressure like `dout`; reset value 0.
- Undefined: port `dout_last` and its logic are absent; all other behaviour identical.

## Test plan
- Single word: after reset, din=0xDDCCBBAA pulse valid, dout_ready=1 → dout 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting 1 cycle after accept; dout_last high only on 0xDD; then dout_valid 0.
- Streaming: 0x03020100, 0x07060504 back-to-back, dout_ready=1 → 0x00..0x07 on 8 consecutive cycles, no gap; din_ready high only at cycles 0 and 4.
- Backpressure: same word, dout_ready=0 for 3 cycles while slice 0xBB shown → dout stays 0xBB, dout_valid 1, din_ready 0; resumes 0xCC,0xDD after release.
- Input stall: din_valid low between words for 5 cycles → dout_valid drops after 0xDD, returns exactly 1 cycle after next accept; no duplicate or stale slice.
- Reset mid-word: assert rst after 0xBB transferred → next cycle dout_valid 0, dout 0; new word 0x44332211 yields 0x11,0x22,0x33,0x44 with no 0xCC/0xDD.
- Random: random din_valid/dout_ready (50%), 1000 words, chained after `skid_buffer` → scoreboard matches all slices in order, no loss or duplication.
